// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two ALU requesters and the
// shared-ALU arbiter. master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int W = 16
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_x;
    logic [W-1:0] req0_y;
    logic [5:0]   req0_ctl;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_x;
    logic [W-1:0] req1_y;
    logic [5:0]   req1_ctl;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_out;
    logic         rsp_zr;
    logic         rsp_ng;

    logic         busy;

    modport master (
        output req0_valid, req0_x, req0_y, req0_ctl,
        output req1_valid, req1_x, req1_y, req1_ctl,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_zr, rsp_ng,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_ctl,
        input  req1_valid, req1_x, req1_y, req1_ctl,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_zr, rsp_ng,
        output busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 16-bit Hack ALU, one operation in
// flight. Accept in IDLE, compute and register the result in EXEC, hold the
// response in RESP until the consumer takes it.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to make req0 win every tie
// (no last-grant history). Default build is round-robin on ties.
//
// state | meaning
// IDLE  | waiting for a request; reqN_ready offered to the arbitration winner
// EXEC  | operands captured; ALU output registered into the response
// RESP  | rsp_valid held with stable payload until rsp_ready

module hack_alu #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [5:0]   ctl,   // {zx,nx,zy,ny,f,no}
    output logic [W-1:0] out,
    output logic         zr,
    output logic         ng
);
    logic [W-1:0] x_z, x_n, y_z, y_n, f_out;

    // Hack ALU datapath: zero/negate each input, add or AND, optionally negate.
    always_comb begin
        x_z   = ctl[5] ? '0 : x;
        x_n   = ctl[4] ? ~x_z : x_z;
        y_z   = ctl[3] ? '0 : y;
        y_n   = ctl[2] ? ~y_z : y_z;
        f_out = ctl[1] ? (x_n + y_n) : (x_n & y_n);   // carry out of the MSB is dropped
        out   = ctl[0] ? ~f_out : f_out;
        zr    = (out == '0);
        ng    = out[W-1];
    end
endmodule

module alu_arbiter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;

    logic [W-1:0] op_x;
    logic [W-1:0] op_y;
    logic [5:0]   op_ctl;
    logic         op_id;

    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [W-1:0] rsp_out_q;
    logic         rsp_zr_q;
    logic         rsp_ng_q;
    logic         busy_q;

    logic         grant0;
    logic         grant1;
    logic         ready0;
    logic         ready1;
    logic         accept;

    logic [W-1:0] alu_out;
    logic         alu_zr;
    logic         alu_ng;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: req0 always wins when both are valid.
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid & ~bus.req0_valid;
    end
`else
    // last_grant: 1 means req1 was granted last, so req0 wins the next tie.
    logic last_grant;

    // Round-robin on ties; a lone requester wins regardless of history.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    end
`endif

    // Ready is only offered in IDLE and never while reset is held.
    always_comb begin
        ready0 = grant0 & (state == IDLE) & rst_n;
        ready1 = grant1 & (state == IDLE) & rst_n;
        accept = ready0 | ready1;
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_out    = rsp_out_q;
    assign bus.rsp_zr     = rsp_zr_q;
    assign bus.rsp_ng     = rsp_ng_q;
    assign bus.busy       = busy_q;

    // The single shared ALU only ever sees the captured operand registers.
    hack_alu #(.W(W)) u_alu (
        .x   (op_x),
        .y   (op_y),
        .ctl (op_ctl),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // Sequencer: capture on accept, register result, hold until consumed.
    // An async reset mid-operation simply drops everything; nothing replays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_x        <= '0;
            op_y        <= '0;
            op_ctl      <= '0;
            op_id       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= '0;
            rsp_zr_q    <= 1'b0;
            rsp_ng_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_x   <= ready1 ? bus.req1_x   : bus.req0_x;
                        op_y   <= ready1 ? bus.req1_y   : bus.req0_y;
                        op_ctl <= ready1 ? bus.req1_ctl : bus.req0_ctl;
                        op_id  <= ready1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= ready1;
`endif
                        busy_q <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_out_q   <= alu_out;
                    rsp_zr_q    <= alu_zr;
                    rsp_ng_q    <= alu_ng;
                    rsp_id_q    <= op_id;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    // Going back through IDLE costs a cycle, so no accept
                    // can overlap the handshake cycle.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for the shared-ALU arbiter with
// hand-computed results. Inputs change on the falling edge; outputs are
// sampled on the falling edge or 1 time unit after an input change.
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [5:0] CTL_ADD  = 6'b000010;
    localparam logic [5:0] CTL_SUB  = 6'b010011;
    localparam logic [5:0] CTL_ZERO = 6'b101010;
    localparam logic [5:0] CTL_AND  = 6'b000000;

    alu_arbiter_if #(.W(16)) bus ();

    alu_arbiter #(.W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int n, input logic v, input logic [15:0] x,
                           input logic [15:0] y, input logic [5:0] ctl);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y; bus.req0_ctl = ctl;
        end else begin
            bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y; bus.req1_ctl = ctl;
        end
    endtask

    // One isolated request from requester n with rsp_ready high; checks the
    // accept cycle, the EXEC cycle, the N+2 response and the return to IDLE.
    task automatic run_single(input int n, input logic [15:0] x, input logic [15:0] y,
                              input logic [5:0] ctl, input logic [15:0] eout,
                              input logic ezr, input logic eng);
        set_req(n, 1'b1, x, y, ctl);
        #1;
        chk("acc_ready0", 16'(bus.req0_ready), 16'(n == 0));
        chk("acc_ready1", 16'(bus.req1_ready), 16'(n == 1));
        chk("acc_busy", 16'(bus.busy), 16'd0);
        tick();
        set_req(n, 1'b0, 16'h0, 16'h0, 6'h0);
        #1;
        chk("exec_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("exec_busy", 16'(bus.busy), 16'd1);
        chk("exec_ready", 16'(bus.req0_ready | bus.req1_ready), 16'd0);
        tick();
        chk("resp_valid", 16'(bus.rsp_valid), 16'd1);
        chk("resp_out", bus.rsp_out, eout);
        chk("resp_zr", 16'(bus.rsp_zr), 16'(ezr));
        chk("resp_ng", 16'(bus.rsp_ng), 16'(eng));
        chk("resp_id", 16'(bus.rsp_id), 16'(n));
        tick();
        chk("idle_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("idle_busy", 16'(bus.busy), 16'd0);
        chk("idle_out_hold", bus.rsp_out, eout);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int exp_id;
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 16'h0, 16'h0, 6'h0);
        set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
        @(negedge clk);
        @(negedge clk);

        // Reset values; ready must stay low during reset even with valid high
        chk("rst_ready0", 16'(bus.req0_ready), 16'd0);
        chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("rst_rsp_out", bus.rsp_out, 16'h0000);
        chk("rst_zr", 16'(bus.rsp_zr), 16'd0);
        chk("rst_ng", 16'(bus.rsp_ng), 16'd0);
        chk("rst_id", 16'(bus.rsp_id), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single requests: add, subtract, constant zero
        run_single(0, 16'd5, 16'd3, CTL_ADD, 16'h0008, 1'b0, 1'b0);
        run_single(1, 16'd3, 16'd5, CTL_SUB, 16'hFFFE, 1'b0, 1'b1);
        run_single(0, 16'h1234, 16'h5678, CTL_ZERO, 16'h0000, 1'b1, 1'b0);

        // Both valid from reset: 0,1,0,1 round-robin (0,0,0,0 fixed priority)
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 16'd10, 16'd4, CTL_ADD);
        set_req(1, 1'b1, 16'd7, 16'd2, CTL_SUB);
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = i % 2;
`endif
            chk("tie_ready0", 16'(bus.req0_ready), 16'(exp_id == 0));
            chk("tie_ready1", 16'(bus.req1_ready), 16'(exp_id == 1));
            tick();
            chk("tie_exec_ready", 16'(bus.req0_ready | bus.req1_ready), 16'd0);
            tick();
            chk("tie_rsp_valid", 16'(bus.rsp_valid), 16'd1);
            chk("tie_rsp_id", 16'(bus.rsp_id), 16'(exp_id));
            chk("tie_rsp_out", bus.rsp_out, (exp_id == 1) ? 16'd5 : 16'd14);
            chk("tie_resp_ready", 16'(bus.req0_ready | bus.req1_ready), 16'd0);
            if (i == 3) begin
                set_req(0, 1'b0, 16'h0, 16'h0, 6'h0);
                set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
            end
            tick();
        end
        chk("tie_end_busy", 16'(bus.busy), 16'd0);

        // Backpressure: result held 4+ cycles, overflow into the sign bit
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 16'h7FFF, 16'h0001, CTL_ADD);
        set_req(1, 1'b1, 16'h0001, 16'h0001, CTL_AND);
        #1;
        chk("bp_ready0", 16'(bus.req0_ready), 16'd1);
        chk("bp_ready1", 16'(bus.req1_ready), 16'd0);
        tick();
        tick();
        chk("bp_rsp_out", bus.rsp_out, 16'h8000);
        chk("bp_rsp_ng", 16'(bus.rsp_ng), 16'd1);
        chk("bp_rsp_zr", 16'(bus.rsp_zr), 16'd0);
        chk("bp_rsp_id", 16'(bus.rsp_id), 16'd0);
        for (int k = 0; k < 4; k++) begin
            chk("bp_hold_valid", 16'(bus.rsp_valid), 16'd1);
            chk("bp_hold_out", bus.rsp_out, 16'h8000);
            chk("bp_hold_ready0", 16'(bus.req0_ready), 16'd0);
            chk("bp_hold_ready1", 16'(bus.req1_ready), 16'd0);
            chk("bp_hold_busy", 16'(bus.busy), 16'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_hs_valid", 16'(bus.rsp_valid), 16'd1);
        chk("bp_hs_ready", 16'(bus.req0_ready | bus.req1_ready), 16'd0);
        tick();
        chk("bp_after_valid", 16'(bus.rsp_valid), 16'd0);
        chk("bp_after_busy", 16'(bus.busy), 16'd0);
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("bp_next_ready0", 16'(bus.req0_ready), 16'd1);
        chk("bp_next_ready1", 16'(bus.req1_ready), 16'd0);
`else
        chk("bp_next_ready0", 16'(bus.req0_ready), 16'd0);
        chk("bp_next_ready1", 16'(bus.req1_ready), 16'd1);
`endif
        tick();
        set_req(0, 1'b0, 16'h0, 16'h0, 6'h0);
        set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
        tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("bp_next_id", 16'(bus.rsp_id), 16'd0);
        chk("bp_next_out", bus.rsp_out, 16'h8000);
`else
        chk("bp_next_id", 16'(bus.rsp_id), 16'd1);
        chk("bp_next_out", bus.rsp_out, 16'h0001);
`endif
        tick();

        // Reset abort during EXEC: no response, reset values, no replay
        set_req(1, 1'b1, 16'd2, 16'd2, CTL_ADD);
        #1;
        chk("ab_ready1", 16'(bus.req1_ready), 16'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("ab_rst_ready1", 16'(bus.req1_ready), 16'd0);
        chk("ab_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("ab_busy", 16'(bus.busy), 16'd0);
        chk("ab_rsp_out", bus.rsp_out, 16'h0000);
        chk("ab_rsp_id", 16'(bus.rsp_id), 16'd0);
        chk("ab_rsp_ng", 16'(bus.rsp_ng), 16'd0);
        set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ab_no_replay", 16'(bus.rsp_valid), 16'd0);
            chk("ab_idle_busy", 16'(bus.busy), 16'd0);
        end
        // First tie after reset goes to req0; 0xFFFF+1 wraps to zero
        set_req(0, 1'b1, 16'hFFFF, 16'h0001, CTL_ADD);
        set_req(1, 1'b1, 16'd3, 16'd3, CTL_ADD);
        #1;
        chk("post_ready0", 16'(bus.req0_ready), 16'd1);
        chk("post_ready1", 16'(bus.req1_ready), 16'd0);
        tick();
        set_req(0, 1'b0, 16'h0, 16'h0, 6'h0);
        set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
        tick();
        chk("post_valid", 16'(bus.rsp_valid), 16'd1);
        chk("post_out", bus.rsp_out, 16'h0000);
        chk("post_zr", 16'(bus.rsp_zr), 16'd1);
        chk("post_ng", 16'(bus.rsp_ng), 16'd0);
        chk("post_id", 16'(bus.rsp_id), 16'd0);
        tick();
        chk("post_idle_valid", 16'(bus.rsp_valid), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
